// File: rtl/banked_line_memory_if.sv
// Request/response bundle between the L1 requestors and banked_line_memory.
// Ports are packed side by side: port p owns slice [p*W +: W] of every per-port bus.
interface banked_line_memory_if #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 128,
  parameter int ADDR_W    = 32
);
  // Handshake: a requestor raises req_valid[p] with its fields and holds both
  // until the cycle where resp_ready[p] pulses, then drops req_valid[p] on the
  // next edge. The fields are captured on the accepting edge.
  logic [NUM_PORTS-1:0]          req_valid;
  logic [NUM_PORTS-1:0]          req_rw;
  logic [NUM_PORTS*ADDR_W-1:0]   req_addr;
  logic [NUM_PORTS*LINE_W-1:0]   req_data;
  logic [NUM_PORTS*LINE_W/8-1:0] req_be;
  logic [NUM_PORTS-1:0]          resp_ready;
  logic [LINE_W-1:0]             resp_data;
  logic                          busy;

  modport master (
    output req_valid, req_rw, req_addr, req_data, req_be,
    input  resp_ready, resp_data, busy
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data, req_be,
    output resp_ready, resp_data, busy
  );
endinterface

// File: rtl/banked_line_memory.sv
// Shared line memory for the L1 caches: round-robin arbitration over NUM_PORTS
// requestors, fixed LATENCY per access, per-byte write enables.
module banked_line_memory #(
  parameter int NUM_PORTS = 2,
  parameter int LINE_W    = 128,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 5
) (
  input  logic                clock,
  input  logic                reset,
  banked_line_memory_if.slave bus,
  output logic [1:0]          dbg_state
);
  localparam int BYTES  = LINE_W / 8;
  localparam int OFF    = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PORT_W-1:0]    grant_q, grant_d;
  logic                 rw_q, rw_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LINE_W-1:0]    data_q, data_d;
  logic [BYTES-1:0]     be_q, be_d;
  logic [NUM_PORTS-1:0] resp_ready_q, resp_ready_d;
  logic [LINE_W-1:0]    resp_data_q, resp_data_d;
  logic                 busy_q, busy_d;

  logic [LINE_W-1:0]    line_mem [DEPTH];

  logic                 grant_found;
  logic [PORT_W-1:0]    grant_idx;
  logic                 sel_rw;
  logic [IDX_W-1:0]     sel_idx;
  logic [LINE_W-1:0]    sel_data;
  logic [BYTES-1:0]     sel_be;
  logic                 mem_we;

  // First valid port at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_found && bus.req_valid[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
        grant_found = 1'b1;
        grant_idx   = PORT_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
      end
    end
  end

  // Only the line-index bits of the address matter; higher bits alias.
  always_comb begin
    sel_rw   = bus.req_rw[grant_idx];
    sel_idx  = bus.req_addr[int'(grant_idx) * ADDR_W + OFF +: IDX_W];
    sel_data = bus.req_data[int'(grant_idx) * LINE_W +: LINE_W];
    sel_be   = bus.req_be[int'(grant_idx) * BYTES +: BYTES];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    rw_d         = rw_q;
    idx_d        = idx_q;
    data_d       = data_q;
    be_d         = be_q;
    resp_ready_d = '0;
    resp_data_d  = '0;
    busy_d       = busy_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (grant_found) begin
          grant_d  = grant_idx;
          rw_d     = sel_rw;
          idx_d    = sel_idx;
          data_d   = sel_data;
          be_d     = sel_be;
          rr_ptr_d = (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = S_WAIT;
          busy_d   = 1'b1;
        end
      end
      S_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q == '0) begin
          state_d               = S_RESP;
          resp_ready_d[grant_q] = 1'b1;
          resp_data_d           = rw_q ? '0 : line_mem[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      rw_q         <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      be_q         <= '0;
      resp_ready_q <= '0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      rw_q         <= rw_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      be_q         <= be_d;
      resp_ready_q <= resp_ready_d;
      resp_data_q  <= resp_data_d;
      busy_q       <= busy_d;
    end
  end

  // The write commits on the edge leaving RESP; a reset on that edge cancels it.
  assign mem_we = (state_q == S_RESP) && rw_q && !reset;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_q[b]) line_mem[idx_q][b*8 +: 8] <= data_q[b*8 +: 8];
      end
    end
  end

  assign bus.resp_ready = resp_ready_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.busy       = busy_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_banked_line_memory.sv
// Bench for banked_line_memory: directed scenarios plus random two-port traffic,
// checked every cycle against a timestamp-based reference model.
module tb_banked_line_memory;
  localparam int NUM_PORTS = 2;
  localparam int LINE_W    = 128;
  localparam int DEPTH     = 1024;
  localparam int ADDR_W    = 32;
  localparam int LATENCY   = 5;
  localparam int BYTES     = LINE_W / 8;
  localparam int T_BUDGET  = 200;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  banked_line_memory_if #(.NUM_PORTS(NUM_PORTS), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  banked_line_memory #(
    .NUM_PORTS(NUM_PORTS), .LINE_W(LINE_W), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Timestamps are edge numbers: an access accepted on edge n pulses after
  // edge n+LATENCY, commits on edge n+LATENCY+1, and the next acceptance can
  // happen no earlier than edge n+LATENCY+2 (after one IDLE cycle).
  int                cyc = 0;
  bit                model_on = 1'b0;
  bit                pend = 1'b0;
  int                done_edge = 0;
  int                next_acc = 0;
  int                rr = 0;
  int                g, cand;
  int                pend_port;
  logic              pend_rw;
  int                pend_idx;
  logic [LINE_W-1:0] pend_data;
  logic [BYTES-1:0]  pend_be;
  logic [ADDR_W-1:0] a_cap;
  logic [LINE_W-1:0] mem_model [int];
  logic [LINE_W-1:0] exp_q[$];
  bit                exp_known_q[$];

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      pend     = 1'b0;
      rr       = 0;
      next_acc = cyc + 1;
      model_on = 1'b1;
      exp_q.delete();
      exp_known_q.delete();
    end else if (model_on) begin
      if (pend && cyc == done_edge + 1) begin
        if (pend_rw) begin
          if (!mem_model.exists(pend_idx)) mem_model[pend_idx] = '0;
          for (int b = 0; b < BYTES; b++)
            if (pend_be[b]) mem_model[pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
        end
        pend = 1'b0;
      end
      if (!pend && cyc >= next_acc) begin
        g = -1;
        for (int k = 0; k < NUM_PORTS; k++) begin
          cand = (rr + k) % NUM_PORTS;
          if (g < 0 && bus.req_valid[cand] === 1'b1) g = cand;
        end
        if (g >= 0) begin
          a_cap     = bus.req_addr[g*ADDR_W +: ADDR_W];
          pend_idx  = int'((a_cap / BYTES) % DEPTH);
          pend_rw   = bus.req_rw[g];
          pend_data = bus.req_data[g*LINE_W +: LINE_W];
          pend_be   = bus.req_be[g*BYTES +: BYTES];
          pend_port = g;
          rr        = (g + 1) % NUM_PORTS;
          done_edge = cyc + LATENCY;
          next_acc  = done_edge + 2;
          pend      = 1'b1;
          if (pend_rw) begin
            exp_q.push_back('0);
            exp_known_q.push_back(1'b1);
          end else if (mem_model.exists(pend_idx)) begin
            exp_q.push_back(mem_model[pend_idx]);
            exp_known_q.push_back(1'b1);
          end else begin
            exp_q.push_back('0);
            exp_known_q.push_back(1'b0);
          end
        end
      end
    end
  end

  // ---------------- output monitor / requestor release ----------------
  logic [NUM_PORTS-1:0] exp_ready;
  logic [LINE_W-1:0]    exp_line;
  bit                   exp_known;
  int                   done_cnt [NUM_PORTS];
  logic [LINE_W-1:0]    last_data [NUM_PORTS];
  int                   issue_edge [NUM_PORTS];
  int                   log_port[$];
  int                   log_cyc[$];

  always @(negedge clock) begin
    if (model_on) begin
      exp_ready = '0;
      if (pend && cyc == done_edge) exp_ready[pend_port] = 1'b1;
      chk("resp_ready", LINE_W'(bus.resp_ready), LINE_W'(exp_ready));
      chk("busy", LINE_W'(bus.busy), LINE_W'(pend && cyc <= done_edge));
      if (exp_ready != '0 && exp_q.size() > 0) begin
        exp_line  = exp_q.pop_front();
        exp_known = exp_known_q.pop_front();
        if (exp_known) chk("resp_data", bus.resp_data, exp_line);
      end else begin
        chk("resp_data_idle", bus.resp_data, '0);
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.resp_ready[p] === 1'b1) begin
          bus.req_valid[p] = 1'b0;
          done_cnt[p]      = done_cnt[p] + 1;
          last_data[p]     = bus.resp_data;
          log_port.push_back(p);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int p, input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] d, input logic [BYTES-1:0] be);
    bus.req_rw[p]                     = rw;
    bus.req_addr[p*ADDR_W +: ADDR_W]  = a;
    bus.req_data[p*LINE_W +: LINE_W]  = d;
    bus.req_be[p*BYTES +: BYTES]      = be;
    bus.req_valid[p]                  = 1'b1;
    issue_edge[p]                     = cyc + 1;
  endtask

  task automatic wait_done(input int p, input int target);
    int n = 0;
    while (done_cnt[p] < target && n < T_BUDGET) begin
      step();
      n++;
    end
    if (done_cnt[p] < target) begin
      chk($sformatf("timeout_p%0d", p), 1, 0);
      bus.req_valid[p] = 1'b0;
    end
  endtask

  task automatic xfer(input int p, input logic rw, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d, input logic [BYTES-1:0] be);
    int t = done_cnt[p] + 1;
    issue(p, rw, a, d, be);
    wait_done(p, t);
  endtask

  task automatic read_line(input int p, input logic [ADDR_W-1:0] a, output logic [LINE_W-1:0] d);
    xfer(p, 1'b0, a, '0, '0);
    d = last_data[p];
  endtask

  task automatic do_reset(input int n);
    reset         = 1'b1;
    bus.req_valid = '0;
    repeat (n) step();
    reset = 1'b0;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic run_port(input int p, input int n_ops);
    logic [ADDR_W-1:0] a;
    logic [BYTES-1:0]  be;
    logic              rw;
    for (int i = 0; i < n_ops; i++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, 3) * DEPTH * BYTES + $urandom_range(0, 15) * BYTES
                   + $urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) == 0) be = '1;
      else for (int b = 0; b < BYTES; b++) be[b] = 1'($urandom_range(0, 1));
      xfer(p, rw, a, rand_line(), be);
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [LINE_W-1:0] rd, v_old, v_new, v5;
  int                t_cnt;

  initial begin
    bus.req_valid = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      done_cnt[p]   = 0;
      last_data[p]  = '0;
      issue_edge[p] = 0;
    end

    // 1: reset held 3 cycles, then 10 quiet cycles
    repeat (3) step();
    chk("rst_ready", LINE_W'(bus.resp_ready), '0);
    chk("rst_data", bus.resp_data, '0);
    chk("rst_busy", LINE_W'(bus.busy), '0);
    reset = 1'b0;
    repeat (10) step();
    chk("quiet_ready", LINE_W'(bus.resp_ready), '0);
    chk("quiet_busy", LINE_W'(bus.busy), '0);

    // Give every line the random phase can touch a known value.
    for (int l = 0; l < 32; l++) xfer(0, 1'b1, ADDR_W'(l * BYTES), rand_line(), '1);

    // 2: full write then read-back, latency from acceptance edge
    xfer(0, 1'b1, 32'h40, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '1);
    chk("t2_latency", LINE_W'(log_cyc[$] - issue_edge[0]), LINE_W'(LATENCY));
    chk("t2_port", LINE_W'(log_port[$]), 0);
    read_line(0, 32'h40, rd);
    chk("t2_readback", rd, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);

    // 3: partial byte-enable write on line 4
    xfer(1, 1'b1, 32'h40, '1, '1);
    xfer(1, 1'b1, 32'h40, '0, 16'h000F);
    read_line(1, 32'h40, rd);
    chk("t3_partial", rd, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    // 4: simultaneous requests straight after reset -> p0, p1, p0
    do_reset(2);
    log_port.delete();
    log_cyc.delete();
    t_cnt = done_cnt[1];
    issue(0, 1'b0, 32'h40, '0, '0);
    issue(1, 1'b0, 32'h80, '0, '0);
    wait_done(0, done_cnt[0] + 1);
    issue(0, 1'b0, 32'h90, '0, '0);
    wait_done(1, t_cnt + 1);
    wait_done(0, done_cnt[0] + 1);
    chk("t4_count", LINE_W'(log_port.size()), 3);
    if (log_port.size() >= 3) begin
      chk("t4_first", LINE_W'(log_port[0]), 0);
      chk("t4_second", LINE_W'(log_port[1]), 1);
      chk("t4_third", LINE_W'(log_port[2]), 0);
      // pulse-to-pulse: LATENCY edges, the RESP->IDLE edge, the IDLE->accept edge
      chk("t4_gap1", LINE_W'(log_cyc[1] - log_cyc[0]), LINE_W'(LATENCY + 2));
      chk("t4_gap2", LINE_W'(log_cyc[2] - log_cyc[1]), LINE_W'(LATENCY + 2));
    end

    // 5: requestor scribbles on its inputs after acceptance
    v5    = rand_line();
    t_cnt = done_cnt[0];
    issue(0, 1'b1, 32'h80, v5, '1);
    step();
    bus.req_addr[0 +: ADDR_W]  = 32'h90;
    bus.req_data[0 +: LINE_W]  = ~v5;
    bus.req_be[0 +: BYTES]     = 16'h00FF;
    wait_done(0, t_cnt + 1);
    read_line(0, 32'h80, rd);
    chk("t5_no_corrupt", rd, v5);

    // 6: reset during a write abandons it; aliased address hits the same line
    v_old = rand_line();
    v_new = ~v_old;
    xfer(1, 1'b1, 32'h100, v_old, '1);
    t_cnt = done_cnt[0];
    issue(0, 1'b1, 32'h100, v_new, '1);
    step();
    step();
    step();
    reset         = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    reset = 1'b0;
    repeat (LATENCY + 2) step();
    chk("t6_no_pulse", LINE_W'(done_cnt[0]), LINE_W'(t_cnt));
    read_line(1, ADDR_W'(32'h100 + DEPTH * BYTES), rd);
    chk("t6_alias_old", rd, v_old);

    // random two-port traffic against the model
    fork
      run_port(0, 25);
      run_port(1, 25);
    join
    repeat (LATENCY + 4) step();
    chk("final_idle_busy", LINE_W'(bus.busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
